// File: rtl/dcache_sa2_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; a miss stalls the pipeline while the
// victim line is written back (if dirty) and the requested line is refilled.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   p1_addr_i/data_i    CPU byte address (word aligned) and store data
//   p1_MemRead_i/Write_i  load / store request (both high = store)
//   p1_data_o           load data (combinational on a read hit)
//   p1_stall_o          pipeline stall while the request is not a hit
//   mem_data_i/ack_i    refill line and one-cycle completion pulse
//   mem_data_o/addr_o   writeback line and line-aligned address
//   mem_enable_o        memory request, mem_write_o: 1 = writeback, 0 = refill
//   hit_cnt_o/miss_cnt_o  performance counters
//
// Build option: define DCACHE_PERF_CNT_EN to build the hit/miss counters;
// otherwise both counter outputs are tied to zero.
module dcache_sa2_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
  localparam int unsigned WSEL_W = OFF_W - BYTE_W;
  localparam int unsigned LSB_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e            state_q;
  logic              valid_q [2][SETS];
  logic              dirty_q [2][SETS];
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [LINE_W-1:0] line_q  [2][SETS];
  // Per-set way to evict next when both ways are valid.
  logic              lru_q   [SETS];

  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;
  logic              victim_q;
  logic              mem_enable_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;
  logic [LSB_W-1:0]  word_lsb;
  logic              req, idle, hit_w0, hit_w1, hit, miss, hit_way, victim;

  assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx  = p1_addr_i[OFF_W +: IDX_W];
  assign req_word = p1_addr_i[BYTE_W +: WSEL_W];
  assign word_lsb = {req_word, {(LSB_W - WSEL_W){1'b0}}};

  if (BYTE_W > 0) begin : g_byte_off
    logic unused_byte_off;
    assign unused_byte_off = ^p1_addr_i[BYTE_W-1:0];
  end

  assign req     = p1_MemRead_i | p1_MemWrite_i;
  assign idle    = (state_q == StIdle);
  assign hit_w0  = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit_w1  = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit     = idle & req & (hit_w0 | hit_w1);
  assign miss    = idle & req & ~(hit_w0 | hit_w1);
  assign hit_way = ~hit_w0;
  // Fill an empty way first (way 0 preferred), else evict the LRU way.
  assign victim  = !valid_q[0][req_idx] ? 1'b0 :
                   !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

  assign p1_stall_o   = miss | ~idle;
  assign p1_data_o    = (hit && !p1_MemWrite_i) ?
                        line_q[hit_way][req_idx][word_lsb +: DATA_W] : '0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
        dirty_q[0][s] <= 1'b0;
        dirty_q[1][s] <= 1'b0;
        lru_q[s]      <= 1'b0;
      end
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      victim_q     <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            lru_q[req_idx] <= ~hit_way;
            if (p1_MemWrite_i) begin
              line_q[hit_way][req_idx][word_lsb +: DATA_W] <= p1_data_i;
              dirty_q[hit_way][req_idx] <= 1'b1;
            end
          end else if (miss) begin
            miss_tag_q   <= req_tag;
            miss_idx_q   <= req_idx;
            victim_q     <= victim;
            mem_enable_q <= 1'b1;
            if (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[victim][req_idx], req_idx, {OFF_W{1'b0}}};
              mem_data_q  <= line_q[victim][req_idx];
            end else begin
              state_q     <= StAllocate;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            state_q     <= StAllocate;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
          end
        end
        StAllocate: begin
          if (mem_ack_i) begin
            state_q                      <= StIdle;
            mem_enable_q                 <= 1'b0;
            line_q[victim_q][miss_idx_q] <= mem_data_i;
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
            valid_q[victim_q][miss_idx_q] <= 1'b1;
            dirty_q[victim_q][miss_idx_q] <= 1'b0;
            lru_q[miss_idx_q]            <= ~victim_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  // Marks the IDLE cycle right after a refill, whose hit belongs to a miss.
  logic        refill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= (state_q == StAllocate) && mem_ack_i;
      if (hit && !refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss)             miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_sa2_ctrl.sv
// Self-checking bench for dcache_sa2_ctrl (default parameters). A memory
// responder with configurable latency backs the cache; a reference model keeps
// each set as a recency-ordered list of whole lines (index 0 = most recent).
module tb_dcache_sa2_ctrl;

  localparam int LINES = 64;
`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
  logic         rd, wr, p1_stall_o;
  logic [255:0] mem_data_i, mem_data_o;
  logic         mem_ack_i, mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o, hit_cnt_o, miss_cnt_o;

  always #5 clk = ~clk;

  dcache_sa2_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_MemRead_i (rd),
    .p1_MemWrite_i(wr),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t         txlog[$];
  logic [255:0] mem [LINES];
  int           lat = 2;
  int           cyc = 0;
  int           ack_cyc = -10;
  int           checks = 0;
  int           errors = 0;
  int           exp_hits = 0;
  int           exp_miss = 0;

  // Reference cache: per set, up to two lines in recency order.
  int           m_cnt   [16];
  int           m_ln    [16][2];
  logic [255:0] m_data  [16][2];
  bit           m_dirty [16][2];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks after 'lat' waiting cycles, logs every transaction.
  initial begin : responder
    int   wcnt;
    int   li;
    txn_t t;
    wcnt = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (mem_enable_o === 1'b1 && rst_i === 1'b0) begin
        if (wcnt < lat) begin
          wcnt++;
        end else begin
          wcnt = 0;
          t.wr = mem_write_o;
          t.addr = mem_addr_o;
          t.data = mem_data_o;
          txlog.push_back(t);
          li = int'(mem_addr_o[10:5]);
          if (mem_addr_o < 32'(LINES * 32)) begin
            if (mem_write_o) mem[li] = mem_data_o;
            else mem_data_i = mem[li];
          end
          mem_ack_i = 1'b1;
          ack_cyc = cyc;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit_cnt"}, hit_cnt_o, PERF ? 256'(exp_hits) : 256'd0);
    chk({tag, "_miss_cnt"}, miss_cnt_o, PERF ? 256'(exp_miss) : 256'd0);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) begin
      m_cnt[s] = 0;
      m_dirty[s][0] = 1'b0;
      m_dirty[s][1] = 1'b0;
    end
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    model_clear();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    #1;
    chk("idle_stall", p1_stall_o, 1'b0);
    chk("idle_mem_en", mem_enable_o, 1'b0);
  endtask

  // One CPU access, checked end to end against the reference model.
  task automatic access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata);
    int           s, ln, w, pos, n, nt;
    bit           exp_wb;
    logic [31:0]  first_addr;
    logic [255:0] tmp_d;
    int           tmp_l;
    bit           tmp_y;
    s = int'(addr[8:5]);
    ln = int'(addr[31:5]);
    w = int'(addr[4:2]);
    pos = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_ln[s][i] == ln) pos = i;
    @(negedge clk);
    txlog.delete();
    p1_addr_i = addr;
    p1_data_i = wdata;
    wr = is_wr;
    rd = is_wr ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    chk("stall_on_request", p1_stall_o, pos < 0);
    if (pos >= 0) begin
      exp_hits++;
      chk("hit_no_mem", mem_enable_o, 1'b0);
      if (pos == 1) begin
        tmp_l = m_ln[s][0];   m_ln[s][0] = m_ln[s][1];     m_ln[s][1] = tmp_l;
        tmp_d = m_data[s][0]; m_data[s][0] = m_data[s][1]; m_data[s][1] = tmp_d;
        tmp_y = m_dirty[s][0]; m_dirty[s][0] = m_dirty[s][1]; m_dirty[s][1] = tmp_y;
      end
    end else begin
      exp_miss++;
      exp_wb = (m_cnt[s] == 2) && m_dirty[s][1];
      first_addr = exp_wb ? 32'(m_ln[s][1] * 32) : 32'(ln * 32);
      @(posedge clk);
      #1;
      chk("miss_mem_en", mem_enable_o, 1'b1);
      chk("miss_mem_write", mem_write_o, exp_wb);
      chk("miss_mem_addr", mem_addr_o, first_addr);
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (p1_stall_o && n < 300);
      chk("stall_release", p1_stall_o, 1'b0);
      chk("release_cycle", cyc, ack_cyc + 1);
      nt = exp_wb ? 2 : 1;
      chk("txn_count", txlog.size(), nt);
      if (txlog.size() == nt) begin
        if (exp_wb) begin
          chk("wb_kind", txlog[0].wr, 1'b1);
          chk("wb_addr", txlog[0].addr, first_addr);
          chk("wb_data", txlog[0].data, m_data[s][1]);
        end
        chk("refill_kind", txlog[nt-1].wr, 1'b0);
        chk("refill_addr", txlog[nt-1].addr, 32'(ln * 32));
      end
      m_ln[s][1] = m_ln[s][0];
      m_data[s][1] = m_data[s][0];
      m_dirty[s][1] = m_dirty[s][0];
      m_ln[s][0] = ln;
      m_data[s][0] = mem[ln];
      m_dirty[s][0] = 1'b0;
      if (m_cnt[s] < 2) m_cnt[s]++;
    end
    if (is_wr) begin
      m_data[s][0][w*32 +: 32] = wdata;
      m_dirty[s][0] = 1'b1;
    end else begin
      chk("load_data", p1_data_o, m_data[s][0][w*32 +: 32]);
    end
    @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a;
    rst_i = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    for (int i = 0; i < LINES; i++)
      for (int j = 0; j < 8; j++) mem[i][j*32 +: 32] = $urandom();
    mem[2][31:0] = 32'hDEADBEEF;
    model_clear();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_stall", p1_stall_o, 1'b0);
    chk("rst_p1_data", p1_data_o, 32'd0);
    chk("rst_mem_en", mem_enable_o, 1'b0);
    chk("rst_mem_write", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 256'd0);
    chk_cnt("rst");

    // Cold load, then store hit and reload of the same word.
    lat = 5;
    access(1'b0, 32'h40, '0);
    chk("cold_load_word", m_data[2][0][31:0], 32'hDEADBEEF);
    lat = 2;
    access(1'b1, 32'h44, 32'h12345678);
    access(1'b0, 32'h44, '0);
    chk("store_then_load", p1_data_o, 32'h12345678);

    // Set-0 conflicts: dirty LRU writeback, then clean LRU eviction.
    access(1'b1, 32'h000, 32'hA5A5_0001);
    access(1'b0, 32'h200, '0);
    access(1'b0, 32'h400, '0);
    access(1'b0, 32'h200, '0);
    access(1'b0, 32'h600, '0);
    access(1'b0, 32'h000, '0);

    // Reset while a refill is outstanding.
    lat = 40;
    @(negedge clk);
    txlog.delete();
    p1_addr_i = 32'h0A0;
    rd = 1'b1;
    wr = 1'b0;
    #1;
    chk("rst_mid_stall", p1_stall_o, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_mid_alloc_en", mem_enable_o, 1'b1);
    chk("rst_mid_alloc_wr", mem_write_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    rd = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_abandon", mem_enable_o, 1'b0);
    chk("rst_mid_no_txn", txlog.size(), 0);
    @(negedge clk);
    rst_i = 1'b0;
    model_clear();
    lat = 2;
    access(1'b0, 32'h0A0, '0);
    access(1'b0, 32'h040, '0);

    // Counter scenario: three misses followed by four first-time hits.
    do_reset();
    lat = 1;
    access(1'b0, 32'h000, '0);
    access(1'b0, 32'h020, '0);
    access(1'b1, 32'h040, 32'h0BAD_F00D);
    access(1'b0, 32'h004, '0);
    access(1'b1, 32'h024, 32'h1111_2222);
    access(1'b0, 32'h048, '0);
    access(1'b0, 32'h040, '0);
    idle_cycle();
    chk("perf_hits4", hit_cnt_o, PERF ? 32'd4 : 32'd0);
    chk("perf_miss3", miss_cnt_o, PERF ? 32'd3 : 32'd0);

    // Randomised traffic over 4 sets x 4 tags to force conflicts.
    for (int k = 0; k < 300; k++) begin
      lat = $urandom_range(0, 4);
      a = 32'(($urandom_range(0, 3) * 16 + $urandom_range(0, 3)) * 32
              + $urandom_range(0, 7) * 4);
      access($urandom_range(0, 2) == 0, a, $urandom());
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
    idle_cycle();
    chk_cnt("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
